count_pulse_gen: RTL and testbench

COUNT_PULSE_GEN -- requirements
Module: count_pulse_gen

---
 rtl/count_pulse_gen.sv | 191 +++++++++++++++++++
 tb/tb_count_pulse_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_pulse_gen.sv
// Debounced up/down buttons to active-low count clocks for a decade counter,
// with optional auto-repeat and a lockout when both buttons are held.
module count_pulse_gen #(
  parameter int unsigned DB_CYCLES    = 50000,
  parameter int unsigned PULSE_W      = 4,
  parameter int unsigned REPEAT_EN    = 1,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic clk,
  input  logic clr,
  input  logic up_btn,
  input  logic dn_btn,
  output logic clkup,
  output logic clkdown,
  output logic busy,
  output logic lockout
);

  localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
  localparam int unsigned T_MAX_A = (PULSE_W > REPEAT_DELAY) ? PULSE_W : REPEAT_DELAY;
  localparam int unsigned TMR_MAX = (T_MAX_A > REPEAT_RATE) ? T_MAX_A : REPEAT_RATE;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_DELAY,
    S_RATE,
    S_LOCK
  } state_t;

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]      sync1, sync2;
  logic [1:0]      pressed;
  logic [1:0]      db, db_q;
  logic [1:0]      press_edge;
  logic [DB_W-1:0] db_cnt [2];

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt, tmr_inc;
  logic              dir, dir_nxt;
  logic              first_pulse, first_pulse_nxt;
  logic              sel_pressed;
  logic              both;

  // Raw buttons are released-high; sync flops reset to the released level.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {dn_btn, up_btn};
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  // Per-button debounce: flip only after DB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      db   <= 2'b00;
      db_q <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      db_q <= db;
      for (int i = 0; i < 2; i++) begin
        if (pressed[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press_edge  = db & ~db_q;
  assign both        = db[0] & db[1];
  assign sel_pressed = dir ? db[1] : db[0];
  assign tmr_inc     = (tmr == TMR_W'(TMR_MAX)) ? tmr : tmr + TMR_W'(1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= S_IDLE;
      tmr         <= '0;
      dir         <= 1'b0;
      first_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      tmr         <= tmr_nxt;
      dir         <= dir_nxt;
      first_pulse <= first_pulse_nxt;
    end
  end

  // The timer keeps running from PULSE into RATE so RATE is measured falling-to-falling.
  always_comb begin
    state_nxt       = state;
    tmr_nxt         = tmr_inc;
    dir_nxt         = dir;
    first_pulse_nxt = first_pulse;
    case (state)
      S_IDLE: begin
        tmr_nxt = '0;
        if (both) begin
          state_nxt = S_LOCK;
        end else if (press_edge == 2'b01) begin
          state_nxt       = S_PULSE;
          dir_nxt         = 1'b0;
          first_pulse_nxt = 1'b1;
        end else if (press_edge == 2'b10) begin
          state_nxt       = S_PULSE;
          dir_nxt         = 1'b1;
          first_pulse_nxt = 1'b1;
        end
      end
      S_PULSE: begin
        if (tmr == TMR_W'(PULSE_W - 1)) begin
          if (both) begin
            state_nxt = S_LOCK;
            tmr_nxt   = '0;
          end else if ((REPEAT_EN != 0) && sel_pressed) begin
            if (first_pulse) begin
              state_nxt = S_DELAY;
              tmr_nxt   = '0;
            end else begin
              state_nxt = S_RATE;
            end
          end else begin
            state_nxt = S_IDLE;
            tmr_nxt   = '0;
          end
        end
      end
      S_DELAY: begin
        if (both) begin
          state_nxt = S_LOCK;
          tmr_nxt   = '0;
        end else if (!sel_pressed) begin
          state_nxt = S_IDLE;
          tmr_nxt   = '0;
        end else if (tmr == TMR_W'(REPEAT_DELAY - 1)) begin
          state_nxt       = S_PULSE;
          tmr_nxt         = '0;
          first_pulse_nxt = 1'b0;
        end
      end
      S_RATE: begin
        if (both) begin
          state_nxt = S_LOCK;
          tmr_nxt   = '0;
        end else if (!sel_pressed) begin
          state_nxt = S_IDLE;
          tmr_nxt   = '0;
        end else if (tmr == TMR_W'(REPEAT_RATE - 1)) begin
          state_nxt       = S_PULSE;
          tmr_nxt         = '0;
          first_pulse_nxt = 1'b0;
        end
      end
      S_LOCK: begin
        tmr_nxt = '0;
        if (db == 2'b00) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

  // Outputs are flops decoded from the next state, so they are glitch-free.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      clkup   <= 1'b1;
      clkdown <= 1'b1;
      busy    <= 1'b0;
      lockout <= 1'b0;
    end else begin
      clkup   <= !((state_nxt == S_PULSE) && !dir_nxt);
      clkdown <= !((state_nxt == S_PULSE) && dir_nxt);
      busy    <= (state_nxt != S_IDLE);
      lockout <= (state_nxt == S_LOCK) || both;
    end
  end

endmodule

// File: tb/tb_count_pulse_gen.sv
// Self-checking bench for count_pulse_gen: vector table plus scoreboard of
// expected pulse falling-edge cycles.
module tb_count_pulse_gen;

  localparam int unsigned DB  = 4;
  localparam int unsigned PW  = 2;
  localparam int unsigned RD  = 20;
  localparam int unsigned RR  = 8;
  localparam int          LAT = 2 + DB + 1;

  logic clk = 1'b0;
  logic clr;
  logic up_btn, dn_btn, up_nr, dn_nr;
  logic clkup, clkdown, busy, lockout;
  logic clkup_nr, clkdown_nr, busy_nr, lockout_nr;

  count_pulse_gen #(
    .DB_CYCLES(DB), .PULSE_W(PW), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .clr(clr), .up_btn(up_btn), .dn_btn(dn_btn),
    .clkup(clkup), .clkdown(clkdown), .busy(busy), .lockout(lockout)
  );

  count_pulse_gen #(
    .DB_CYCLES(DB), .PULSE_W(PW), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_nr (
    .clk(clk), .clr(clr), .up_btn(up_nr), .dn_btn(dn_nr),
    .clkup(clkup_nr), .clkdown(clkdown_nr), .busy(busy_nr), .lockout(lockout_nr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int q_up[$];
  int q_dn[$];
  int falls_up = 0, falls_dn = 0, nr_falls = 0, nr_fall_t = -1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Expected falling-edge cycles for a press starting after cycle c0 held for h cycles.
  task automatic exp_hold(input bit dn, input int c0, input int h);
    int  f;
    int  last;
    bit  first;
    f     = c0 + LAT;
    last  = c0 + h + 2 + DB;
    first = 1'b1;
    if (h >= int'(DB)) begin
      while (f <= last) begin
        if (dn) q_dn.push_back(f);
        else    q_up.push_back(f);
        f     = f + (first ? int'(PW + RD) : int'(RR));
        first = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: pops expected fall times, checks widths and exclusivity.
  initial begin : monitor
    logic pu, pd, pnu, pnd;
    int   fu, fd, fnu, fnd;
    pu = 1; pd = 1; pnu = 1; pnd = 1;
    fu = 0; fd = 0; fnu = 0; fnd = 0;
    forever begin
      @(negedge clk);
      if (!clr) begin
        pu = 1; pd = 1; pnu = 1; pnd = 1;
      end else begin
        if (!clkup || !clkdown) check("never_both_low", int'(!clkup && !clkdown), 0);
        if (pu && !clkup) begin
          falls_up++;
          fu = cyc;
          if (q_up.size() == 0) check("unexpected_up_pulse", cyc, -1);
          else check("up_fall_cycle", cyc, q_up.pop_front());
        end
        if (!pu && clkup) check("up_width", cyc - fu, int'(PW));
        if (pd && !clkdown) begin
          falls_dn++;
          fd = cyc;
          if (q_dn.size() == 0) check("unexpected_dn_pulse", cyc, -1);
          else check("dn_fall_cycle", cyc, q_dn.pop_front());
        end
        if (!pd && clkdown) check("dn_width", cyc - fd, int'(PW));
        if (pnu && !clkup_nr) begin
          nr_falls++;
          nr_fall_t = cyc;
          fnu = cyc;
        end
        if (!pnu && clkup_nr) check("nr_up_width", cyc - fnu, int'(PW));
        if (pnd && !clkdown_nr) begin
          nr_falls++;
          fnd = cyc;
        end
        if (!pnd && clkdown_nr) check("nr_dn_width", cyc - fnd, int'(PW));
        pu = clkup; pd = clkdown; pnu = clkup_nr; pnd = clkdown_nr;
      end
    end
  end

  typedef struct {
    bit dn;
    int hold;
    int exp_pulses;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int c0, c1, u0, d0, n0;
    vecs[0] = '{1'b0, 10, 1};
    vecs[1] = '{1'b1, 10, 1};
    vecs[2] = '{1'b0, int'(DB) - 1, 0};
    vecs[3] = '{1'b0, int'(DB), 1};
    vecs[4] = '{1'b0, 60, 6};
    vecs[5] = '{1'b1, 30, 2};
    vecs[6] = '{1'b1, 60, 6};

    clr = 1'b0;
    up_btn = 1'b1; dn_btn = 1'b1; up_nr = 1'b1; dn_nr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_clkup", int'(clkup), 1);
    check("rst_clkdown", int'(clkdown), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_lockout", int'(lockout), 0);
    check("rst_nr_clkup", int'(clkup_nr), 1);
    check("rst_nr_busy", int'(busy_nr), 0);
    clr = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_rst_busy", int'(busy), 0);

    // Table: taps, debounce boundary, auto-repeat on both buttons.
    for (int v = 0; v < 7; v++) begin
      u0 = falls_up; d0 = falls_dn;
      @(negedge clk);
      c0 = cyc;
      exp_hold(vecs[v].dn, c0, vecs[v].hold);
      if (vecs[v].dn) dn_btn = 1'b0;
      else            up_btn = 1'b0;
      repeat (vecs[v].hold) @(negedge clk);
      up_btn = 1'b1; dn_btn = 1'b1;
      repeat (2 + DB + RR + 12) @(negedge clk);
      check($sformatf("vec%0d_pulses", v),
            vecs[v].dn ? falls_dn - d0 : falls_up - u0, vecs[v].exp_pulses);
      check($sformatf("vec%0d_other", v), vecs[v].dn ? falls_up - u0 : falls_dn - d0, 0);
      check($sformatf("vec%0d_queue", v), q_up.size() + q_dn.size(), 0);
      check($sformatf("vec%0d_busy", v), int'(busy), 0);
    end

    // Bounce rejection.
    u0 = falls_up; d0 = falls_dn;
    for (int i = 0; i < 15; i++) begin
      dn_btn = (i % 2 == 1);
      repeat (2) @(negedge clk);
    end
    dn_btn = 1'b1;
    repeat (20) @(negedge clk);
    check("bounce_pulses", (falls_up - u0) + (falls_dn - d0), 0);
    check("bounce_busy", int'(busy), 0);

    // Lockout: down held, up joins 30 cycles later.
    u0 = falls_up; d0 = falls_dn;
    @(negedge clk);
    c0 = cyc;
    q_dn.push_back(c0 + LAT);
    q_dn.push_back(c0 + LAT + int'(PW + RD));
    dn_btn = 1'b0;
    repeat (30) @(negedge clk);
    up_btn = 1'b0;
    repeat (15) @(negedge clk);
    check("lock_lockout", int'(lockout), 1);
    check("lock_busy", int'(busy), 1);
    repeat (15) @(negedge clk);
    up_btn = 1'b1;
    repeat (15) @(negedge clk);
    check("lock_one_released", int'(lockout), 1);
    repeat (5) @(negedge clk);
    dn_btn = 1'b1;
    repeat (20) @(negedge clk);
    check("lock_released_lockout", int'(lockout), 0);
    check("lock_released_busy", int'(busy), 0);
    check("lock_dn_pulses", falls_dn - d0, 2);
    check("lock_up_pulses", falls_up - u0, 0);
    check("lock_queue", q_dn.size(), 0);

    // Reset mid-pulse, button held through reset release.
    d0 = falls_dn;
    @(negedge clk);
    c0 = cyc;
    q_dn.push_back(c0 + LAT);
    dn_btn = 1'b0;
    repeat (LAT) @(negedge clk);
    #1;
    check("rst_pre_clkdown", int'(clkdown), 0);
    clr = 1'b0;
    #1;
    check("rst_async_clkdown", int'(clkdown), 1);
    check("rst_async_clkup", int'(clkup), 1);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_lockout", int'(lockout), 0);
    repeat (3) @(negedge clk);
    c1 = cyc;
    clr = 1'b1;
    exp_hold(1'b1, c1, 12);
    repeat (12) @(negedge clk);
    dn_btn = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_dn_pulses", falls_dn - d0, 2);
    check("rst_queue", q_dn.size(), 0);

    // Auto-repeat disabled instance.
    u0 = falls_up; d0 = falls_dn; n0 = nr_falls;
    @(negedge clk);
    c0 = cyc;
    up_nr = 1'b0;
    repeat (100) @(negedge clk);
    up_nr = 1'b1;
    repeat (20) @(negedge clk);
    check("norep_pulses", nr_falls - n0, 1);
    check("norep_fall_cycle", nr_fall_t, c0 + LAT);
    check("norep_busy", int'(busy_nr), 0);
    check("norep_main_quiet", (falls_up - u0) + (falls_dn - d0), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
